// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// One request at a time: valid/ready request phase, then a single-cycle response pulse.
interface mem_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: turns core lw/sw requests into bus transactions and stalls the core
// until completion; illegal requests and timeouts finish with a one-cycle err pulse.
module mem_lsu #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lw_en,
    input  logic        sw_en,
    input  logic [2:0]  func3,
    input  logic [31:0] base,
    input  logic [31:0] ext_imm,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        err,
    mem_lsu_if.master   bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] load_data_q, load_data_d;
    logic        err_pend_q, err_pend_d;
    logic        orphan_q, orphan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] ea;
    logic        f3_ok, aligned, legal;
    logic [3:0]  strb_new;
    logic [31:0] wdata_new;

    assign ea = base + ext_imm;

    // Request legality and store lane formatting, evaluated on the live core inputs in IDLE.
    always_comb begin
        f3_ok = sw_en ? (!func3[2] && func3[1:0] != 2'b11)
                      : (func3[1:0] != 2'b11 && func3 != 3'b110);
        case (func3[1:0])
            2'b01:   aligned = !ea[0];
            2'b10:   aligned = (ea[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        legal = f3_ok && aligned && !(lw_en && sw_en);
        case (func3[1:0])
            2'b00: begin
                strb_new  = 4'b0001 << ea[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            2'b01: begin
                strb_new  = 4'b0011 << {ea[1], 1'b0};
                wdata_new = {2{store_data[15:0]}};
            end
            default: begin
                strb_new  = 4'b1111;
                wdata_new = store_data;
            end
        endcase
    end

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] ext_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_b = rbyte[lane_q];
        sel_h = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (func3_q)
            3'b000:  ext_word = {{24{sel_b[7]}}, sel_b};
            3'b100:  ext_word = {24'b0, sel_b};
            3'b001:  ext_word = {{16{sel_h[15]}}, sel_h};
            3'b101:  ext_word = {16'b0, sel_h};
            default: ext_word = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            func3_q     <= '0;
            lane_q      <= '0;
            load_data_q <= '0;
            err_pend_q  <= 1'b0;
            orphan_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            func3_q     <= func3_d;
            lane_q      <= lane_d;
            load_data_q <= load_data_d;
            err_pend_q  <= err_pend_d;
            orphan_q    <= orphan_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        func3_d     = func3_q;
        lane_d      = lane_q;
        load_data_d = load_data_q;
        err_pend_d  = err_pend_q;
        cnt_d       = cnt_q;
        // A response left over from a timed-out access is swallowed wherever it shows up.
        orphan_d    = orphan_q && !bus.mem_rsp_valid;
        case (state_q)
            S_IDLE: begin
                if (lw_en || sw_en) begin
                    func3_d = func3;
                    lane_d  = ea[1:0];
                    if (legal) begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        addr_d      = {ea[31:2], 2'b00};
                        we_d        = sw_en;
                        wstrb_d     = sw_en ? strb_new : 4'b0000;
                        wdata_d     = wdata_new;
                        err_pend_d  = 1'b0;
                    end else begin
                        state_d     = S_DONE;
                        err_pend_d  = 1'b1;
                        load_data_d = '0;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d     = S_WAIT;
                    req_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_rsp_valid && !orphan_q) begin
                    state_d = S_DONE;
                    if (!we_q) load_data_d = ext_word;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = S_DONE;
                    err_pend_d  = 1'b1;
                    orphan_d    = 1'b1;
                    load_data_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                err_pend_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
    end

    always_comb begin
        stall = (state_q == S_IDLE) ? (lw_en || sw_en) : (state_q != S_DONE);
        err   = (state_q == S_DONE) && err_pend_q;
        load_data         = load_data_q;
        bus.mem_req_valid = req_valid_q;
        bus.mem_addr      = addr_q;
        bus.mem_we        = we_q;
        bus.mem_wstrb     = wstrb_q;
        bus.mem_wdata     = wdata_q;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit directly downstream of the single-cycle core.
- Consumes the core's lw_en/sw_en, base register, sign-extended immediate, store data and func3.
- Runs the access on a valid/ready data-memory bus and returns the extended load word on the core's data_mem input.
- Asserts stall so the core holds PC and register writeback until the access completes.

Parameters:
- TIMEOUT, 64, cycles allowed in WAIT for a response before aborting with err.
- CNT_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lw_en  in  1  load request from core control
- sw_en  in  1  store request from core control
- func3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- base  in  32  rs1 value (core data1)
- ext_imm  in  32  sign-extended offset
- store_data  in  32  rs2 value (core data2)
- load_data  out  32  extended load result to core data_mem
- stall  out  1  core must hold state this cycle
- err  out  1  one-cycle pulse: misaligned, illegal func3, lw_en&sw_en both high, or timeout
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_addr  out  32  word-aligned address ({ea[31:2],2'b00})
- mem_we  out  1  1 = store
- mem_wstrb  out  4  byte lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  response/ack pulse
- mem_rdata  in  32  read word

Behaviour:
- Effective address: ea = base + ext_imm, mod 2^32. Computed combinationally in IDLE and latched together with func3, we and data on leaving IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - lw_en|sw_en with a legal request → REQ; stall=1 that cycle.
  - Illegal request → DONE with err_pending; no bus activity.
  - Otherwise stays IDLE with stall=0.
- Illegal request means any of: misaligned (h with ea[0]=1, w with ea[1:0]!=0), func3 outside the set (stores also reject 1xx), or lw_en&sw_en both high.
- REQ: mem_req_valid=1 with stable addr/we/wstrb/wdata until mem_req_ready=1 sampled high → WAIT. No timeout in REQ. stall=1.
- WAIT:
  - stall=1; counter increments each cycle.
  - mem_rsp_valid → DONE. On a load, load_data is registered from mem_rdata: select the lane by ea[1:0], then sign- or zero-extend per func3.
  - Counter reaching TIMEOUT → DONE with err_pending and orphan=1.
- DONE:
  - stall=0 for exactly one cycle so the core commits and the PC advances at this edge.
  - err pulses here if err_pending; load_data=0 on error.
  - Always returns to IDLE. A request is never re-issued from DONE.
- orphan: the next mem_rsp_valid seen in any state is discarded (clears orphan). It is never taken as the response for a new request. If orphan is set when a new request reaches WAIT, the first response clears orphan and the second completes the access.
- wstrb:
  - sb: 4'b0001<<ea[1:0]
  - sh: 4'b0011<<{ea[1],1'b0}
  - sw: 4'b1111
- wdata: sb replicates byte 4×; sh replicates half 2×; sw passes through.
- Response earliest the cycle after acceptance. A response in the same cycle as acceptance is a bus protocol violation and is ignored.
- Reset values: state=IDLE, mem_req_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, load_data=0, err=0, orphan=0, counter=0. stall is combinational, so it is 1 immediately after reset if lw_en is already high.
- Reset mid-transaction drops mem_req_valid next cycle. The in-flight response is not tracked (orphan=0); the bus is required to be reset together with this block.
- Latency: best case, a load or store seen in IDLE at cycle 0 gives REQ at 1, accept at 1, response at 2, DONE at 3. That is 3 stall cycles, with commit at the end of cycle 3.

Test Plan:
- lw: base=0x1000, imm=4, ready=1, rsp at +1 with rdata=0xDEADBEEF → mem_addr=0x1004, we=0, stall high 3 cycles, load_data=0xDEADBEEF in DONE, err=0.
- lb/lbu: ea=0x2003, rdata=0x80112233 → lb load_data=0xFFFFFF80; lbu load_data=0x00000080; mem_addr=0x2000.
- sh: ea=0x3002, store_data=0x0000ABCD → we=1, wstrb=4'b1100, wdata=0xABCDABCD; ready held low 5 cycles keeps valid/addr/wdata stable throughout.
- lw at ea=0x1001 → no mem_req_valid, DONE next cycle, err pulse 1 cycle, load_data=0. lw_en&sw_en both high → same response.
- TIMEOUT=4, no response → err in DONE after 4 WAIT cycles. A late rsp during the next lw is discarded; its second rsp (0x12345678) is returned.
- rst asserted in WAIT → next cycle state IDLE, mem_req_valid=0, load_data=0, err=0.
